// File: rtl/axi_lite_ram_slave_pkg.sv
// Shared definitions for the AXI4-Lite RAM responder: response codes,
// channel FSM state encodings and the address window check.
package axi_lite_ram_slave_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_RAM, R_RESP} rstate_t;

  // True when addr falls in the RAM window starting at base; only the bits
  // above the byte offset of the last word take part in the comparison.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned aw);
    return ((addr ^ base) >> (aw + 2)) == 32'd0;
  endfunction

endpackage

// File: rtl/axi_lite_ram_slave_bram_be.sv
// Single-port 2^ADDR_WIDTH x 32 RAM with per-byte write enables and a
// registered read port. Each byte lane is its own array so every lane maps
// onto a plain block RAM. The read register only updates on re, so the last
// read word stays on dout while writes go on.
module bram_be #(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic [3:0]            we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           din,
  output logic [31:0]           dout
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [0:(1<<ADDR_WIDTH)-1];
      logic [7:0] q_reg;

      // Byte lane: write under its strobe, registered read on re.
      always_ff @(posedge clk) begin
        if (we[gi]) mem[addr] <= din[8*gi +: 8];
        if (re)     q_reg     <= mem[addr];
      end

      assign dout[8*gi +: 8] = q_reg;
    end
  endgenerate

endmodule

// File: rtl/axi_lite_ram_slave.sv
// AXI4-Lite responder serving reads and writes from an internal word RAM.
// Read and write channels have independent FSMs sharing one RAM port; a
// write commit owns the port, so a read waiting on it sees the new data.
module axi_lite_ram_slave
  import axi_lite_ram_slave_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] axi_araddr,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  input  logic [2:0]  axi_arprot,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  input  logic [31:0] axi_awaddr,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [2:0]  axi_awprot,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  output logic [1:0]  axi_bresp,
  output logic        axi_bvalid,
  input  logic        axi_bready
);

  wstate_t     w_state_reg;
  logic        aw_latched_reg, w_latched_reg;
  logic [31:0] awaddr_reg, wdata_reg;
  logic [3:0]  wstrb_reg;
  logic        awready_reg, wready_reg, bvalid_reg;
  logic [1:0]  bresp_reg;

  rstate_t     r_state_reg;
  logic [31:0] araddr_reg;
  logic        arready_reg, rvalid_reg, rdata_en_reg;
  logic [1:0]  rresp_reg;

  logic                  aw_hs, w_hs, ar_hs, aw_have, w_have;
  logic                  w_commit, w_in_range, r_in_range;
  logic [3:0]            ram_we;
  logic                  ram_re;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]           ram_dout;

  // Protection bits carry no meaning for this RAM.
  logic unused_prot;
  assign unused_prot = ^{axi_arprot, axi_awprot};

  assign aw_hs   = axi_awvalid && awready_reg;
  assign w_hs    = axi_wvalid && wready_reg;
  assign ar_hs   = axi_arvalid && arready_reg;
  assign aw_have = aw_latched_reg || aw_hs;
  assign w_have  = w_latched_reg || w_hs;

  assign w_commit   = (w_state_reg == W_COMMIT);
  assign w_in_range = addr_in_range(awaddr_reg, BASE_ADDR, ADDR_WIDTH);
  assign r_in_range = addr_in_range(araddr_reg, BASE_ADDR, ADDR_WIDTH);

  // A commit cut short by reset must leave the RAM untouched.
  assign ram_we   = (w_commit && w_in_range && !rst) ? wstrb_reg : 4'b0000;
  assign ram_re   = (r_state_reg == R_RAM) && !w_commit && r_in_range && !rst;
  assign ram_addr = w_commit ? awaddr_reg[ADDR_WIDTH+1:2] : araddr_reg[ADDR_WIDTH+1:2];

  bram_be #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_addr),
    .din  (wdata_reg),
    .dout (ram_dout)
  );

  // Write channel: collect AW and W in any order, commit for one cycle, respond.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_reg    <= W_IDLE;
      aw_latched_reg <= 1'b0;
      w_latched_reg  <= 1'b0;
      awready_reg    <= 1'b0;
      wready_reg     <= 1'b0;
      bvalid_reg     <= 1'b0;
      bresp_reg      <= AXI_RESP_OKAY;
    end else begin
      case (w_state_reg)
        W_IDLE: begin
          if (aw_hs) awaddr_reg <= axi_awaddr;
          if (w_hs) begin
            wdata_reg <= axi_wdata;
            wstrb_reg <= axi_wstrb;
          end
          if (aw_have && w_have) begin
            w_state_reg    <= W_COMMIT;
            aw_latched_reg <= 1'b0;
            w_latched_reg  <= 1'b0;
            awready_reg    <= 1'b0;
            wready_reg     <= 1'b0;
          end else begin
            aw_latched_reg <= aw_have;
            w_latched_reg  <= w_have;
            awready_reg    <= !aw_have;
            wready_reg     <= !w_have;
          end
        end
        W_COMMIT: begin
          w_state_reg <= W_RESP;
          bvalid_reg  <= 1'b1;
          bresp_reg   <= w_in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        end
        W_RESP: begin
          if (axi_bready) begin
            w_state_reg <= W_IDLE;
            bvalid_reg  <= 1'b0;
            awready_reg <= 1'b1;
            wready_reg  <= 1'b1;
          end
        end
        default: w_state_reg <= W_IDLE;
      endcase
    end
  end

  // Read channel: latch address, wait for a free RAM cycle, hold data until rready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_reg  <= R_IDLE;
      arready_reg  <= 1'b0;
      rvalid_reg   <= 1'b0;
      rresp_reg    <= AXI_RESP_OKAY;
      rdata_en_reg <= 1'b0;
    end else begin
      case (r_state_reg)
        R_IDLE: begin
          if (ar_hs) begin
            araddr_reg  <= axi_araddr;
            arready_reg <= 1'b0;
            r_state_reg <= R_RAM;
          end else begin
            arready_reg <= 1'b1;
          end
        end
        R_RAM: begin
          if (!w_commit) begin
            r_state_reg  <= R_RESP;
            rvalid_reg   <= 1'b1;
            rresp_reg    <= r_in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            rdata_en_reg <= r_in_range;
          end
        end
        R_RESP: begin
          if (axi_rready) begin
            r_state_reg  <= R_IDLE;
            rvalid_reg   <= 1'b0;
            arready_reg  <= 1'b1;
            rdata_en_reg <= 1'b0;
          end
        end
        default: r_state_reg <= R_IDLE;
      endcase
    end
  end

  assign axi_awready = awready_reg;
  assign axi_wready  = wready_reg;
  assign axi_bvalid  = bvalid_reg;
  assign axi_bresp   = bresp_reg;
  assign axi_arready = arready_reg;
  assign axi_rvalid  = rvalid_reg;
  assign axi_rresp   = rresp_reg;
  // The RAM read register is stable through R_RESP; gating it keeps rdata at
  // zero for out-of-range reads, while idle and in reset.
  assign axi_rdata   = rdata_en_reg ? ram_dout : 32'd0;

endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// Scoreboard bench for axi_lite_ram_slave: drivers push expected responses
// from a word-array reference model; a negedge monitor pops and compares.
module tb_axi_lite_ram_slave;
  localparam int AW = 12;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] axi_araddr = '0, axi_awaddr = '0, axi_wdata = '0, axi_rdata;
  logic axi_arvalid = 1'b0, axi_awvalid = 1'b0, axi_wvalid = 1'b0;
  logic axi_rready = 1'b0, axi_bready = 1'b0;
  logic axi_arready, axi_awready, axi_wready, axi_rvalid, axi_bvalid;
  logic [2:0] axi_arprot = 3'd0, axi_awprot = 3'd0;
  logic [3:0] axi_wstrb = 4'h0;
  logic [1:0] axi_rresp, axi_bresp;

  always #5 clk = ~clk;

  axi_lite_ram_slave #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_arprot(axi_arprot), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_awprot(axi_awprot), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_bresp(axi_bresp),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] model_mem [0:(1<<AW)-1];

  function automatic bit in_range(input logic [31:0] a);
    return (a >> (AW + 2)) == (BASE >> (AW + 2));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[AW+1:2]);
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (in_range(a))
      for (int b = 0; b < 4; b++)
        if (s[b]) model_mem[widx(a)][8*b +: 8] = d[8*b +: 8];
  endfunction

  typedef struct { logic [1:0] resp; int cyc; } bexp_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; int cyc; } rexp_t;
  bexp_t bq[$];
  rexp_t rq[$];
  int b_issued = 0, b_done = 0, r_issued = 0, r_done = 0;

  // ---------------- monitor ----------------
  bit mon_en = 0;
  bit b_active = 0, r_active = 0, b_reopen = 0, r_reopen = 0;
  int b_wait = 0, r_wait = 0;
  logic [1:0] b_hold, r_hold_resp;
  logic [31:0] r_hold_data;
  bexp_t be;
  rexp_t re;

  always @(negedge clk) begin
    if (!mon_en) begin
      b_active = 0; r_active = 0; b_reopen = 0; r_reopen = 0; b_wait = 0; r_wait = 0;
    end else begin
      if (b_reopen) begin
        check("awready_reopen", axi_awready, 1);
        check("wready_reopen", axi_wready, 1);
        b_reopen = 0;
      end
      if (axi_bvalid) begin
        b_wait = 0;
        check("aw_w_ready_busy", {axi_awready, axi_wready}, 0);
        if (!b_active) begin
          check("b_expected", bq.size() != 0, 1);
          if (bq.size() != 0) begin
            be = bq.pop_front();
            check("bresp", axi_bresp, be.resp);
            check("bvalid_cycle", cyc, be.cyc);
          end
          b_active = 1;
          b_hold = axi_bresp;
        end else begin
          check("bresp_stable", axi_bresp, b_hold);
        end
        if (axi_bready) begin b_active = 0; b_done++; b_reopen = 1; end
      end else if (bq.size() != 0) begin
        b_wait++;
        if (b_wait > 30) begin
          n_checks++; n_fail++;
          $display("FAIL bvalid_timeout: no write response, expected by cycle %0d", bq[0].cyc);
          void'(bq.pop_front()); b_done++; b_wait = 0;
        end
      end

      if (r_reopen) begin
        check("arready_reopen", axi_arready, 1);
        r_reopen = 0;
      end
      if (axi_rvalid) begin
        r_wait = 0;
        check("arready_busy", axi_arready, 0);
        if (!r_active) begin
          check("r_expected", rq.size() != 0, 1);
          if (rq.size() != 0) begin
            re = rq.pop_front();
            check("rdata", axi_rdata, re.data);
            check("rresp", axi_rresp, re.resp);
            check("rvalid_cycle", cyc, re.cyc);
          end
          r_active = 1;
          r_hold_data = axi_rdata;
          r_hold_resp = axi_rresp;
        end else begin
          check("rdata_stable", axi_rdata, r_hold_data);
          check("rresp_stable", axi_rresp, r_hold_resp);
        end
        if (axi_rready) begin r_active = 0; r_done++; r_reopen = 1; end
      end else if (rq.size() != 0) begin
        r_wait++;
        if (r_wait > 30) begin
          n_checks++; n_fail++;
          $display("FAIL rvalid_timeout: no read response, expected by cycle %0d", rq[0].cyc);
          void'(rq.pop_front()); r_done++; r_wait = 0;
        end
      end
    end
  end

  // ---------------- response-ready driver ----------------
  bit hold_ready = 0;
  initial forever begin
    @(posedge clk); #1;
    if (hold_ready) begin
      axi_bready = 1'b0;
      axi_rready = 1'b0;
    end else begin
      axi_bready = ($urandom_range(0, 3) != 0);
      axi_rready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- stimulus tasks (entered at posedge+1) ----------------
  // lead > 0: W presented lead cycles before AW; lead < 0: AW first.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int lead);
    int k = 0;
    bit aw_done = 0, w_done = 0;
    int t_aw = 0, t_w = 0;
    int lead_aw = (lead > 0) ? lead : 0;
    int lead_w = (lead < 0) ? -lead : 0;
    bexp_t e;
    while (!(aw_done && w_done) && k < 50) begin
      if (!aw_done && k >= lead_aw) begin axi_awvalid = 1'b1; axi_awaddr = a; end
      if (!w_done && k >= lead_w) begin axi_wvalid = 1'b1; axi_wdata = d; axi_wstrb = s; end
      @(negedge clk);
      if (w_done && !aw_done) check("wready_low_after_w", axi_wready, 0);
      if (aw_done && !w_done) check("awready_low_after_aw", axi_awready, 0);
      if (axi_awvalid && axi_awready) begin aw_done = 1; t_aw = cyc; end
      if (axi_wvalid && axi_wready) begin w_done = 1; t_w = cyc; end
      @(posedge clk); #1;
      if (aw_done) axi_awvalid = 1'b0;
      if (w_done) axi_wvalid = 1'b0;
      k++;
    end
    axi_awvalid = 1'b0;
    axi_wvalid = 1'b0;
    check("write_handshake", aw_done && w_done, 1);
    if (aw_done && w_done) begin
      e.resp = in_range(a) ? 2'b00 : 2'b10;
      e.cyc = ((t_aw > t_w) ? t_aw : t_w) + 2;
      bq.push_back(e);
      b_issued++;
    end
  endtask

  task automatic do_read(input logic [31:0] a, input int extra);
    int k = 0;
    bit done = 0;
    rexp_t e;
    axi_araddr = a;
    axi_arvalid = 1'b1;
    while (!done && k < 50) begin
      @(negedge clk);
      if (axi_arready) begin
        done = 1;
        e.resp = in_range(a) ? 2'b00 : 2'b10;
        e.data = in_range(a) ? model_mem[widx(a)] : 32'd0;
        e.cyc = cyc + 2 + extra;
        rq.push_back(e);
        r_issued++;
      end
      @(posedge clk); #1;
      if (done) axi_arvalid = 1'b0;
      k++;
    end
    axi_arvalid = 1'b0;
    check("read_handshake", done, 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((b_done != b_issued || r_done != r_issued) && k < 100) begin
      @(posedge clk);
      k++;
    end
    check("drain", (b_done == b_issued) && (r_done == r_issued), 1);
    if (b_done != b_issued || r_done != r_issued) begin
      bq.delete(); rq.delete(); b_issued = b_done; r_issued = r_done;
    end
    @(posedge clk); #1;
  endtask

  // Write and read handshaking in the same cycle: the read's RAM slot meets
  // the write commit, so it is served one cycle late and sees the new data.
  task automatic do_both(input logic [31:0] wa, input logic [31:0] d, input logic [3:0] s, input logic [31:0] ra);
    model_write(wa, d, s);
    fork
      do_write(wa, d, s, 0);
      do_read(ra, 1);
    join
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valids"}, {axi_arready, axi_awready, axi_wready, axi_rvalid, axi_bvalid}, 0);
    check({tag, "_resps"}, {axi_rresp, axi_bresp}, 0);
    check({tag, "_rdata"}, axi_rdata, 0);
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0)
      return ($urandom_range(0, 1) != 0 ? 32'h0001_0000 : 32'h8000_0000) | ($urandom_range(0, 15) << 2);
    return ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
  endfunction

  initial begin
    #(10 * 60000);
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] wa, ra, d;
    logic [3:0] s;
    int op;
    bit waited;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("ready_after_reset", {axi_arready, axi_awready, axi_wready}, 3'b111);
    @(posedge clk); #1;
    mon_en = 1;

    // Preset the words used below.
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      model_write(i * 4, d, 4'hF);
      do_write(i * 4, d, 4'hF, 0);
      wait_idle();
    end

    // AW and W together, then read back.
    model_write(32'h10, 32'hDEADBEEF, 4'hF);
    do_write(32'h10, 32'hDEADBEEF, 4'hF, 0);
    wait_idle();
    do_read(32'h10, 0);
    wait_idle();

    // W three cycles ahead of AW, partial strobes over a zeroed word.
    model_write(32'h14, 32'h0, 4'hF);
    do_write(32'h14, 32'h0, 4'hF, 0);
    wait_idle();
    model_write(32'h14, 32'h11223344, 4'b0101);
    do_write(32'h14, 32'h11223344, 4'b0101, 3);
    wait_idle();
    do_read(32'h14, 0);
    wait_idle();

    // Out of range: SLVERR on both channels, aliased word 0 untouched.
    model_write(32'h0001_0000, 32'hA5A5A5A5, 4'hF);
    do_write(32'h0001_0000, 32'hA5A5A5A5, 4'hF, 0);
    wait_idle();
    do_read(32'h0001_0000, 0);
    wait_idle();
    do_read(32'h0000_0000, 0);
    wait_idle();

    // Backpressure: both responses held for several cycles.
    hold_ready = 1;
    model_write(32'h18, 32'hCAFEF00D, 4'hF);
    do_write(32'h18, 32'hCAFEF00D, 4'hF, 0);
    do_read(32'h18, 0);
    repeat (5) @(negedge clk);
    check("bvalid_held", axi_bvalid, 1);
    check("rvalid_held", axi_rvalid, 1);
    @(posedge clk); #1;
    hold_ready = 0;
    wait_idle();

    // Read/write port conflict on 0x20.
    model_write(32'h20, 32'h1, 4'hF);
    do_write(32'h20, 32'h1, 4'hF, 0);
    wait_idle();
    do_both(32'h20, 32'h2, 4'hF, 32'h20);
    wait_idle();

    // Reset during the write commit: word 0x30 must keep its value.
    mon_en = 0;
    axi_awaddr = 32'h30; axi_wdata = ~model_mem[12]; axi_wstrb = 4'hF;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1;
    @(negedge clk);
    check("commit_rst_handshake", {axi_awready, axi_wready}, 2'b11);
    @(posedge clk); #1;
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_in_commit");
    @(posedge clk); #1;
    @(negedge clk);
    check("ready_after_commit_rst", {axi_arready, axi_awready, axi_wready}, 3'b111);
    @(posedge clk); #1;
    mon_en = 1;
    do_read(32'h30, 0);
    wait_idle();

    // Reset while a read response is pending.
    mon_en = 0;
    hold_ready = 1;
    @(posedge clk); #1;
    axi_araddr = 32'h30;
    axi_arvalid = 1'b1;
    @(negedge clk);
    check("rresp_rst_handshake", axi_arready, 1);
    @(posedge clk); #1;
    axi_arvalid = 1'b0;
    waited = 0;
    for (int k = 0; k < 10 && !waited; k++) begin
      @(negedge clk);
      if (axi_rvalid) waited = 1;
    end
    check("rvalid_before_rst", axi_rvalid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_in_rresp");
    @(posedge clk); #1;
    @(negedge clk);
    check("ready_after_rresp_rst", {axi_arready, axi_awready, axi_wready}, 3'b111);
    @(posedge clk); #1;
    hold_ready = 0;
    mon_en = 1;

    // Randomized traffic.
    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 2);
      wa = rand_addr();
      ra = rand_addr();
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if (op == 0) begin
        model_write(wa, d, s);
        do_write(wa, d, s, int'($urandom_range(0, 6)) - 3);
      end else if (op == 1) begin
        do_read(ra, 0);
      end else begin
        do_both(wa, d, s, ra);
      end
      wait_idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
